// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives a level-held instruction-memory read, skids one
// word when decode stalls, drains abandoned reads after a redirect, and stops on HALT.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_en,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_done,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        id_stall,
    output logic        id_valid,
    output logic [15:0] id_instr,
    output logic [15:0] id_pc,
    output logic [15:0] id_pc_plus2,
    output logic        halted
);

    localparam logic [15:0] NOP_WORD = 16'h0800;
    localparam logic [4:0]  HALT_OP  = 5'b00000;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } stateType;

    stateType    state;
    logic [15:0] pc;
    logic        pending;
    logic [15:0] holdInstr;
    logic [15:0] holdPc;
    logic [15:0] holdPcPlus2;

    logic [15:0] pcPlus2;
    logic        blocked;

    assign pcPlus2   = pc + 16'd2;
    assign blocked   = id_valid && id_stall;
    assign imem_en   = !rst && (state == FETCH);
    assign imem_addr = pc;

    // Redirect wins over every other transition; an outstanding read without a
    // same-cycle completion must be drained so its late word is never consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            pending     <= 1'b0;
            holdInstr   <= 16'h0000;
            holdPc      <= 16'h0000;
            holdPcPlus2 <= 16'h0000;
            id_valid    <= 1'b0;
            id_instr    <= NOP_WORD;
            id_pc       <= 16'h0000;
            id_pc_plus2 <= 16'h0000;
            halted      <= 1'b0;
        end else begin
            if (imem_done) begin
                pending <= 1'b0;
            end else if (imem_en) begin
                pending <= 1'b1;
            end

            if (!blocked) begin
                id_valid <= 1'b0;
                id_instr <= NOP_WORD;
            end

            if (redirect) begin
                pc          <= redirect_pc & 16'hFFFE;
                id_valid    <= 1'b0;
                id_instr    <= NOP_WORD;
                holdInstr   <= 16'h0000;
                holdPc      <= 16'h0000;
                holdPcPlus2 <= 16'h0000;
                halted      <= 1'b0;
                if (!imem_done && pending) begin
                    state <= DRAIN;
                end else begin
                    state <= FETCH;
                end
            end else begin
                case (state)
                    FETCH: begin
                        if (imem_done) begin
                            pc <= pcPlus2;
                            if (blocked) begin
                                holdInstr   <= imem_rdata;
                                holdPc      <= pc;
                                holdPcPlus2 <= pcPlus2;
                                state       <= HOLD;
                            end else begin
                                id_valid    <= 1'b1;
                                id_instr    <= imem_rdata;
                                id_pc       <= pc;
                                id_pc_plus2 <= pcPlus2;
                                if (imem_rdata[15:11] == HALT_OP) begin
                                    state  <= HALTED;
                                    halted <= 1'b1;
                                end
                            end
                        end
                    end
                    HOLD: begin
                        if (!blocked) begin
                            id_valid    <= 1'b1;
                            id_instr    <= holdInstr;
                            id_pc       <= holdPc;
                            id_pc_plus2 <= holdPcPlus2;
                            if (holdInstr[15:11] == HALT_OP) begin
                                state  <= HALTED;
                                halted <= 1'b1;
                            end else begin
                                state <= FETCH;
                            end
                        end
                    end
                    DRAIN: begin
                        if (imem_done) begin
                            state <= FETCH;
                        end
                    end
                    HALTED: begin
                        state <= HALTED;
                    end
                    default: begin
                        state <= FETCH;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 imem_en  out  1  instruction-memory read request, level-held until imem_done.
REQ-006 imem_addr  out  16  fetch address; equals pc whenever imem_en=1.
REQ-007 imem_rdata  in  16  instruction word; valid only in a cycle with imem_done=1.
REQ-008 imem_done  in  1  one-cycle completion of the outstanding read.
REQ-009 redirect  in  1  taken branch/jump from downstream; flushes fetch.
REQ-010 redirect_pc  in  16  new PC; sampled only when redirect=1.
REQ-011 id_stall  in  1  decode stage cannot accept a new IF/ID entry this cycle.
REQ-012 id_valid  out  1  IF/ID entry holds a real instruction.
REQ-013 id_instr  out  16  IF/ID instruction; id_instr[15:11] is the opcode consumed by the decode stage.
REQ-014 id_pc, id_pc_plus2  out  16 each  address of id_instr and that address + 2.
REQ-015 halted  out  1  a HALT (opcode 5'b00000) has been delivered and fetch has stopped.

Function
REQ-016 Registered state: pc[15:0]; FSM {FETCH, HOLD, DRAIN, HALTED}; pending flag; one-entry hold buffer (instr, pc, pc+2); IF/ID register.
REQ-017 The NOP word is 16'h0800. An empty IF/ID entry SHALL have id_valid=0 and id_instr=16'h0800.
REQ-018 IF/ID is "blocked" iff id_valid=1 and id_stall=1. An empty entry is never blocked.
REQ-019 FETCH: imem_en=1, imem_addr=pc. pending SHALL be set on any cycle with imem_en=1 and imem_done=0, and cleared on imem_done.
REQ-020 FETCH with imem_done=1 and IF/ID not blocked: load IF/ID with {imem_rdata, pc, pc+2} and id_valid=1; pc<=pc+2; the next state is HALTED if imem_rdata[15:11]=5'b00000, otherwise FETCH.
REQ-021 FETCH with imem_done=1 and IF/ID blocked: capture {imem_rdata, pc, pc+2} into the hold buffer; pc<=pc+2; go to HOLD.
REQ-022 IF/ID not blocked and nothing loaded this cycle: id_valid<=0 and id_instr<=16'h0800; id_pc and id_pc_plus2 hold.
REQ-023 HOLD: imem_en=0. When IF/ID is no longer blocked, move the hold buffer into IF/ID with id_valid=1, then go to HALTED if the held opcode is 5'b00000, otherwise FETCH.
REQ-024 HALTED: imem_en=0 and halted=1; pc is frozen at halt address + 2. The IF/ID entry follows REQ-022. HALTED is left only via rst or redirect.
REQ-025 pc arithmetic is 16-bit modulo: 16'hFFFE + 2 = 16'h0000. pc is always written even; bit 0 of redirect_pc is ignored and forced to 0.
REQ-026 Redirect has priority over every other transition, in every state:
- pc<=redirect_pc;
- IF/ID is flushed (id_valid<=0, id_instr<=16'h0800);
- the hold buffer is discarded.
REQ-027 Redirect with imem_done=1 in the same cycle: the returned word is discarded; go to FETCH.
REQ-028 Redirect while pending=1 and imem_done=0: go to DRAIN.
- DRAIN drives imem_en=0 until imem_done, discards that word, then goes to FETCH.
- A further redirect in DRAIN updates pc only.
REQ-029 Redirect with pending=0: go to FETCH; the new pc is presented on the next cycle.
REQ-030 imem_addr SHALL be stable while pending=1, except when leaving via REQ-028.
REQ-031 Latency: with imem_done returned in the same cycle as the request, the fetch sustains one instruction per cycle and id_valid rises on the cycle after imem_done.

Reset
REQ-032 While rst=1, imem_en SHALL be 0. On the clock edge with rst=1, the block SHALL set:
- pc=RESET_PC, state=FETCH, pending=0;
- hold buffer and IF/ID zeroed except id_instr=16'h0800;
- id_valid=0, halted=0.
REQ-033 Reset mid-request abandons any outstanding read: the first imem_done after reset releases SHALL be treated as the response to the new request at RESET_PC.

Verification
REQ-034 Streaming: zero-wait memory returns 16'h4000, 16'h4001, 16'h4002 from 0, 2, 4 -> id_valid=1 on three consecutive cycles, with id_pc 0, 2, 4 and id_pc_plus2 2, 4, 6.
REQ-035 Stall skid:
- Stimulus: id_stall=1 for 3 cycles while the memory returns the word at 4.
- Required: IF/ID holds address 2 throughout; state=HOLD; imem_en=0.
- Required: after the stall releases, id_pc=4 with the correct instruction, then fetch resumes at 6.
REQ-036 Redirect while a read is pending (memory 3-cycle latency, redirect to 16'h0100 one cycle after the request) -> DRAIN:
- The late word is discarded.
- The next imem_addr is 16'h0100.
- No id_valid pulse occurs for the discarded word.
REQ-037 Halt:
- Stimulus: the word at 8 is 16'h0000.
- Required: halted=1 the cycle after delivery; imem_en stays 0 for 10 cycles; pc=16'h000A.
- Then redirect to 16'h0020 -> halted=0 and a fetch issues at 16'h0020.
REQ-038 Wrap and simultaneous events:
- Fetch at 16'hFFFE: next imem_addr=16'h0000.
- redirect and imem_done in the same cycle: the word is discarded and id_valid=0 next cycle.
- rst asserted in HOLD: all REQ-032 values hold on the next cycle.
